// File: rtl/execute_stage.sv
// Execute stage of a five-stage MIPS-style pipeline.
// The ALU, branch-target adder and destination mux are combinational; every
// result is captured in the single EX/MEM register, so outputs trail the
// ID/EX inputs by exactly one clock. Reset (which wins over flush) and flush
// both load an all-zero bubble.
module execute_stage #(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [1:0]          ALUOpIn,
  input  logic                RegDstIn,
  input  logic                ALUSrcIn,
  input  logic                BranchIn,
  input  logic                MemReadIn,
  input  logic                MemWriteIn,
  input  logic                MemToRegIn,
  input  logic                RegWriteIn,
  input  logic [31:0]         regA,
  input  logic [31:0]         regB,
  input  logic [31:0]         signExtendIn,
  input  logic [PC_WIDTH-1:0] PcCountIn,
  input  logic [4:0]          rtIn,
  input  logic [4:0]          rdIn,
  output logic                BranchOut,
  output logic                MemReadOut,
  output logic                MemWriteOut,
  output logic                MemToRegOut,
  output logic                RegWriteOut,
  output logic [31:0]         aluResult,
  output logic [31:0]         writeDataOut,
  output logic [4:0]          writeRegisterOut,
  output logic                zeroOut,
  output logic [PC_WIDTH-1:0] branchTarget,
  output logic                branchTaken
);

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_ZERO  = 2'b11
  } alu_op_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  alu_op_t     alu_op;
  logic [5:0]  funct;
  logic [31:0] operand_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  // ALU operand selection and operation decode
  always_comb begin
    alu_op     = alu_op_t'(ALUOpIn);
    funct      = signExtendIn[5:0];
    operand_b  = ALUSrcIn ? signExtendIn : regB;
    alu_result = '0;
    unique case (alu_op)
      ALU_ADD: alu_result = regA + operand_b;
      ALU_SUB: alu_result = regA - operand_b;
      ALU_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_result = regA + operand_b;
          FUNCT_SUB: alu_result = regA - operand_b;
          FUNCT_AND: alu_result = regA & operand_b;
          FUNCT_OR:  alu_result = regA | operand_b;
          FUNCT_NOR: alu_result = ~(regA | operand_b);
          FUNCT_SLT: alu_result = {31'b0, ($signed(regA) < $signed(operand_b))};
          default:   alu_result = '0;
        endcase
      end
      ALU_ZERO: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // EX/MEM pipeline register; reset and flush both insert an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      BranchOut        <= 1'b0;
      MemReadOut       <= 1'b0;
      MemWriteOut      <= 1'b0;
      MemToRegOut      <= 1'b0;
      RegWriteOut      <= 1'b0;
      aluResult        <= '0;
      writeDataOut     <= '0;
      writeRegisterOut <= '0;
      zeroOut          <= 1'b0;
      branchTarget     <= '0;
      branchTaken      <= 1'b0;
    end else begin
      BranchOut        <= BranchIn;
      MemReadOut       <= MemReadIn;
      MemWriteOut      <= MemWriteIn;
      MemToRegOut      <= MemToRegIn;
      RegWriteOut      <= RegWriteIn;
      aluResult        <= alu_result;
      writeDataOut     <= regB;
      writeRegisterOut <= RegDstIn ? rdIn : rtIn;
      zeroOut          <= alu_zero;
      branchTarget     <= PcCountIn + signExtendIn[PC_WIDTH-1:0];
      branchTaken      <= BranchIn & alu_zero;
    end
  end

endmodule
